pmem_line_adapter: RTL and testbench

- Responder for the cache's physical-memory line interface. Accepts one 256-bit line read or write per request and services it as a 4-beat, 64-bit burst toward DRAM or the burst memory model.
- Sits between the cache's pmem_* ports and the memory bus.
- Returns a single-cycle response per line.

---
 rtl/pmem_line_adapter_pkg.sv | 30 +++
 rtl/pmem_line_adapter_if.sv | 37 +++
 rtl/pmem_line_adapter_line_beat_buffer.sv | 42 ++++
 rtl/pmem_line_adapter.sv | 108 ++++++++++
 tb/tb_pmem_line_adapter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_line_adapter_pkg.sv
// pmem_line_adapter_pkg
//   Shared geometry and types for the cache line <-> memory burst adapter.
//   S_OFFSET  : log2 of the line size in bytes (line-aligned burst address)
//   S_LINE    : line width in bits
//   BEAT_W    : burst beat width in bits
//   NUM_BEATS : beats per line (power of two)
package pmem_line_adapter_pkg;

  localparam int S_OFFSET   = 5;
  localparam int S_LINE     = 256;
  localparam int BEAT_W     = 64;
  localparam int NUM_BEATS  = S_LINE / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  // Clears the byte-within-line bits so the memory side always sees a line
  // boundary, whatever offset the cache presented.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/pmem_line_adapter_if.sv
// pmem_line_adapter_if
//   Bundles the cache-side line port and the memory-side burst port.
//   slave  : the adapter (consumes line requests, issues bursts)
//   master : the environment (cache requester plus memory responder)
//
//   Handshakes: line_read/line_write are held high by the requester until it
//   samples the one-cycle line_resp pulse. On the burst side burst_read or
//   burst_write stays high for the whole burst; every cycle burst_resp is high
//   moves exactly one beat, a low cycle is a wait state.
interface pmem_line_adapter_if;
  import pmem_line_adapter_pkg::*;

  logic [31:0]       line_addr;
  logic              line_read;
  logic              line_write;
  logic [S_LINE-1:0] line_wdata;
  logic [S_LINE-1:0] line_rdata;
  logic              line_resp;

  logic [31:0]       burst_addr;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  line_addr, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata
  );

  modport master (
    output line_addr, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata
  );

endinterface

// File: rtl/pmem_line_adapter_line_beat_buffer.sv
// pmem_line_adapter_line_beat_buffer
//   Line storage for both burst directions.
//   clk, rst   : clock, synchronous active-high reset (clears both lines)
//   load_en    : capture load_data as the outgoing write line
//   load_data  : line to be written to memory
//   beat_we    : store beat_wdata into slot beat_idx of the read line
//   beat_idx   : current beat number
//   beat_wdata : incoming read beat
//   rd_line    : assembled read line
//   wr_beat    : slot beat_idx of the latched write line
//
//   Read and write lines are kept apart so a write burst never disturbs the
//   last assembled read line.
module pmem_line_adapter_line_beat_buffer
  import pmem_line_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [S_LINE-1:0] load_data,
  input  logic              beat_we,
  input  beat_idx_t         beat_idx,
  input  logic [BEAT_W-1:0] beat_wdata,
  output logic [S_LINE-1:0] rd_line,
  output logic [BEAT_W-1:0] wr_beat
);

  logic [S_LINE-1:0] wr_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_line <= '0;
      wr_line <= '0;
    end else begin
      if (load_en) wr_line <= load_data;
      if (beat_we) rd_line[beat_idx*BEAT_W +: BEAT_W] <= beat_wdata;
    end
  end

  assign wr_beat = wr_line[beat_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/pmem_line_adapter.sv
// pmem_line_adapter
//   Services one cache line read or write as a NUM_BEATS-beat burst and
//   returns a single-cycle line_resp.
//   clk, rst  : clock, synchronous active-high reset (aborts any burst)
//   bus       : line and burst signals (slave side)
//   dbg_state : current FSM state
//   dbg_beat  : current beat counter
module pmem_line_adapter
  import pmem_line_adapter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  pmem_line_adapter_if.slave bus,
  output state_t    dbg_state,
  output beat_idx_t dbg_beat
);

  state_t            state, state_nxt;
  beat_idx_t         beat, beat_nxt;
  logic [31:0]       addr_q, addr_nxt;
  logic              load_wr;
  logic              capture;
  logic              last_beat;
  logic [BEAT_W-1:0] wr_beat;
  logic [S_LINE-1:0] rd_line;

  assign last_beat = (beat == beat_idx_t'(NUM_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      beat   <= beat_nxt;
      addr_q <= addr_nxt;
    end
  end

  // Read wins when both requests are seen in IDLE. The counter wraps to 0 on
  // the final beat, so it is already cleared when the next burst starts.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    addr_nxt  = addr_q;
    load_wr   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.line_read) begin
          state_nxt = RD_BURST;
          addr_nxt  = line_align(bus.line_addr);
          beat_nxt  = '0;
        end else if (bus.line_write) begin
          state_nxt = WR_BURST;
          addr_nxt  = line_align(bus.line_addr);
          beat_nxt  = '0;
          load_wr   = 1'b1;
        end
      end
      RD_BURST: begin
        if (bus.burst_resp) begin
          capture  = 1'b1;
          beat_nxt = beat_idx_t'(beat + 1'b1);
          if (last_beat) state_nxt = RESP;
        end
      end
      WR_BURST: begin
        if (bus.burst_resp) begin
          beat_nxt = beat_idx_t'(beat + 1'b1);
          if (last_beat) state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  pmem_line_adapter_line_beat_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_wr),
    .load_data  (bus.line_wdata),
    .beat_we    (capture),
    .beat_idx   (beat),
    .beat_wdata (bus.burst_rdata),
    .rd_line    (rd_line),
    .wr_beat    (wr_beat)
  );

  // Request strobes decode straight from the state register, so they rise
  // the cycle after acceptance and drop in RESP without extra flops.
  assign bus.burst_addr  = addr_q;
  assign bus.burst_read  = (state == RD_BURST);
  assign bus.burst_write = (state == WR_BURST);
  assign bus.burst_wdata = (state == WR_BURST) ? wr_beat : '0;
  assign bus.line_resp   = (state == RESP);
  assign bus.line_rdata  = rd_line;

  assign dbg_state = state;
  assign dbg_beat  = beat;

endmodule

// File: tb/tb_pmem_line_adapter.sv
// tb_pmem_line_adapter
//   Directed bench for pmem_line_adapter: driver tasks act as both the cache
//   requester and the burst memory; a negedge monitor checks every burst start,
//   write beat and line_resp against expectation queues.
module tb_pmem_line_adapter;
  import pmem_line_adapter_pkg::*;

  // ---------------- clock / reset ----------------
  logic      clk = 1'b0;
  logic      rst = 1'b1;
  state_t    dbg_state;
  beat_idx_t dbg_beat;

  pmem_line_adapter_if ifc();

  pmem_line_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .dbg_state (dbg_state),
    .dbg_beat  (dbg_beat)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int vec_count   = 0;
  int miscompares = 0;

  logic [S_LINE-1:0] exp_q[$];       // expected line_rdata at each line_resp
  logic [BEAT_W-1:0] exp_beat_q[$];  // expected burst_wdata beats, in order
  logic [31:0]       exp_addr_q[$];  // expected burst_addr at each burst start

  logic [S_LINE-1:0] model_rdata = '0;
  int   cyc            = 0;
  int   resp_count     = 0;
  int   viol_count     = 0;
  int   last_resp_cyc  = 0;
  int   prev_resp_cyc  = 0;
  int   last_start_cyc = 0;
  logic prev_active    = 1'b0;

  task automatic check(input string name, input logic [S_LINE-1:0] act,
                       input logic [S_LINE-1:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vec_count++;
    miscompares++;
    $display("FAIL %s: got an output event, expected none (queue empty)", name);
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_active <= 1'b0;
    end else begin
      prev_active <= ifc.burst_read | ifc.burst_write;
      check("rd_wr_exclusive", S_LINE'(ifc.burst_read & ifc.burst_write), '0);
      if ((ifc.burst_read | ifc.burst_write) && !prev_active) begin
        last_start_cyc <= cyc;
        if (exp_addr_q.size() == 0) unexpected("burst_start");
        else check("burst_addr", S_LINE'(ifc.burst_addr), S_LINE'(exp_addr_q.pop_front()));
      end
      if (ifc.burst_write) begin
        if (exp_beat_q.size() == 0) unexpected("burst_wdata");
        else begin
          check("burst_wdata", S_LINE'(ifc.burst_wdata), S_LINE'(exp_beat_q[0]));
          if (ifc.burst_resp) void'(exp_beat_q.pop_front());
        end
      end
      if (ifc.line_resp) begin
        resp_count    <= resp_count + 1;
        prev_resp_cyc <= last_resp_cyc;
        last_resp_cyc <= cyc;
        check("resp_req_low", S_LINE'({ifc.burst_read, ifc.burst_write}), '0);
        if (exp_q.size() == 0) unexpected("line_resp");
        else check("line_rdata", ifc.line_rdata, exp_q.pop_front());
      end
    end
  end

  // Protocol watch: both requests in IDLE is a requester violation.
  always @(negedge clk) begin
    if (!rst && ifc.line_read && ifc.line_write && dbg_state == IDLE) begin
      viol_count <= viol_count + 1;
      $display("note: simultaneous line_read and line_write at cycle %0d", cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // pat bit i (LSB first) is burst_resp for the i-th burst cycle; past pat_len
  // the memory answers every cycle.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [S_LINE-1:0] line, input logic [15:0] pat,
                         input int pat_len, input logic also_write,
                         input logic release_req, output int latency);
    int n, p, g;
    ifc.line_addr  = addr;
    ifc.line_read  = 1'b1;
    ifc.line_write = also_write;
    exp_addr_q.push_back(exp_addr);
    exp_q.push_back(line);
    model_rdata = line;
    n = 0; p = 0; g = 0; latency = 1;
    while (n < NUM_BEATS && g < 64) begin
      @(posedge clk); #1;
      g++; latency++;
      ifc.burst_resp  = 1'b0;
      ifc.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (ifc.burst_read) begin
        if (p >= pat_len || pat[p]) begin
          ifc.burst_resp  = 1'b1;
          ifc.burst_rdata = line[n*BEAT_W +: BEAT_W];
          n++;
        end
        p++;
      end
    end
    check("read_beats_taken", S_LINE'(n), S_LINE'(NUM_BEATS));
    @(posedge clk); #1;
    latency++;
    ifc.burst_resp = 1'b0;
    g = 0;
    while (!ifc.line_resp && g < 16) begin
      @(posedge clk); #1;
      g++; latency++;
    end
    check("read_resp_seen", S_LINE'(ifc.line_resp), S_LINE'(1));
    if (release_req) begin
      @(posedge clk); #1;
      ifc.line_read  = 1'b0;
      ifc.line_write = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [S_LINE-1:0] line,
                          input logic [BEAT_W-1:0] b0, input logic [BEAT_W-1:0] b1,
                          input logic [BEAT_W-1:0] b2, input logic [BEAT_W-1:0] b3,
                          input logic [15:0] pat, input int pat_len);
    int n, p, g;
    ifc.line_addr  = addr;
    ifc.line_wdata = line;
    ifc.line_write = 1'b1;
    exp_addr_q.push_back(exp_addr);
    exp_beat_q.push_back(b0);
    exp_beat_q.push_back(b1);
    exp_beat_q.push_back(b2);
    exp_beat_q.push_back(b3);
    exp_q.push_back(model_rdata);
    n = 0; p = 0; g = 0;
    while (n < NUM_BEATS && g < 64) begin
      @(posedge clk); #1;
      g++;
      ifc.burst_resp = 1'b0;
      if (ifc.burst_write) begin
        if (p >= pat_len || pat[p]) begin
          ifc.burst_resp = 1'b1;
          n++;
        end
        p++;
      end
    end
    check("write_beats_taken", S_LINE'(n), S_LINE'(NUM_BEATS));
    @(posedge clk); #1;
    ifc.burst_resp = 1'b0;
    g = 0;
    while (!ifc.line_resp && g < 16) begin
      @(posedge clk); #1;
      g++;
    end
    check("write_resp_seen", S_LINE'(ifc.line_resp), S_LINE'(1));
    @(posedge clk); #1;
    ifc.line_write = 1'b0;
    ifc.line_wdata = '1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},       S_LINE'(dbg_state), S_LINE'(IDLE));
    check({tag, "_beat"},        S_LINE'(dbg_beat), '0);
    check({tag, "_line_rdata"},  ifc.line_rdata, '0);
    check({tag, "_line_resp"},   S_LINE'(ifc.line_resp), '0);
    check({tag, "_burst_addr"},  S_LINE'(ifc.burst_addr), '0);
    check({tag, "_burst_rw"},    S_LINE'({ifc.burst_read, ifc.burst_write}), '0);
    check({tag, "_burst_wdata"}, S_LINE'(ifc.burst_wdata), '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    report();
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, g, lat, rc0;
    ifc.line_addr   = '0;
    ifc.line_read   = 1'b0;
    ifc.line_write  = 1'b0;
    ifc.line_wdata  = '0;
    ifc.burst_rdata = '0;
    ifc.burst_resp  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic read, back-to-back beats, minimum latency.
    do_read(32'h0000_1234, 32'h0000_1220,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
            16'h0, 0, 1'b0, 1'b1, lat);
    check("read_latency", S_LINE'(lat), S_LINE'(6));

    // burst_resp outside a burst must be ignored.
    ifc.burst_resp = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    ifc.burst_resp = 1'b0;
    check("idle_resp_ignored", S_LINE'(dbg_state), S_LINE'(IDLE));

    // Write with one wait state; line_rdata must keep the previous read.
    do_write(32'hFFFF_FFE0, 32'hFFFF_FFE0,
             256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0,
             64'h8796A5B4C3D2E1F0, 64'h0F1E2D3C4B5A6978,
             64'hFEDCBA9876543210, 64'h0123456789ABCDEF,
             16'b11101, 5);

    // Read with resp pattern 1,0,0,1,1,0,1.
    do_read(32'h0000_2000, 32'h0000_2000,
            256'hD4D4D4D4D4D4D4D4_C3C3C3C3C3C3C3C3_B2B2B2B2B2B2B2B2_A1A1A1A1A1A1A1A1,
            16'b1011001, 7, 1'b0, 1'b1, lat);
    check("gapped_read_latency", S_LINE'(lat), S_LINE'(9));
    check("gapped_read_beat_wrap", S_LINE'(dbg_beat), '0);

    // Both requests high: read must win and be flagged.
    ifc.line_wdata = 256'hEEEE;
    do_read(32'h0000_0117, 32'h0000_0100,
            256'h9999999999999999_8888888888888888_7777777777777777_6666666666666666,
            16'h0, 0, 1'b1, 1'b1, lat);
    check("simultaneous_req_flagged", S_LINE'(viol_count != 0), S_LINE'(1));

    // Reset after two read beats: abort, no line_resp.
    ifc.line_addr = 32'h0000_3000;
    ifc.line_read = 1'b1;
    exp_addr_q.push_back(32'h0000_3000);
    n = 0; g = 0;
    while (n < 2 && g < 32) begin
      @(posedge clk); #1;
      g++;
      ifc.burst_resp = 1'b0;
      if (ifc.burst_read) begin
        ifc.burst_resp  = 1'b1;
        ifc.burst_rdata = 64'h5555_5555_5555_5550 + 64'(n);
        n++;
      end
    end
    @(posedge clk); #1;
    rst            = 1'b1;
    ifc.burst_resp = 1'b0;
    ifc.line_read  = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midburst_reset");
    rst = 1'b0;
    model_rdata = '0;
    @(posedge clk); #1;

    // Write after abort starts cleanly at beat 0; rdata stays cleared.
    do_write(32'h0000_0040, 32'h0000_0040,
             256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101,
             64'h0101010101010101, 64'h0202020202020202,
             64'h0303030303030303, 64'h0404040404040404,
             16'h0, 0);

    // Back-to-back reads: request held past line_resp.
    rc0 = resp_count;
    do_read(32'h0000_051F, 32'h0000_0500,
            256'hA4A4A4A4A4A4A4A4_A3A3A3A3A3A3A3A3_A2A2A2A2A2A2A2A2_A1A1A1A1A1A1A1A1,
            16'h0, 0, 1'b0, 1'b0, lat);
    do_read(32'h0000_0520, 32'h0000_0520,
            256'hB4B4B4B4B4B4B4B4_B3B3B3B3B3B3B3B3_B2B2B2B2B2B2B2B2_B1B1B1B1B1B1B1B1,
            16'h0, 0, 1'b0, 1'b1, lat);
    repeat (2) begin @(posedge clk); #1; end
    check("b2b_resp_count", S_LINE'(resp_count - rc0), S_LINE'(2));
    check("b2b_restart_gap", S_LINE'(last_start_cyc - prev_resp_cyc), S_LINE'(2));

    repeat (3) begin @(posedge clk); #1; end
    check("resp_queue_drained", S_LINE'(exp_q.size()), '0);
    check("beat_queue_drained", S_LINE'(exp_beat_q.size()), '0);
    check("addr_queue_drained", S_LINE'(exp_addr_q.size()), '0);

    report();
    $finish;
  end

endmodule
